// File: rtl/matrix_op_sequencer.sv
// Sequencer between the 8-row RAM and the matrix ALU: reads operand rows A and B,
// hands them to the ALU, waits (bounded) for the result and writes it back.
// Every output is a flop; output flops load from the next-state decode so each
// value is valid throughout the state it belongs to.
module matrix_op_sequencer #(
  parameter int unsigned DATA_W  = 256,
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [ADDR_W-1:0] addr_dst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_nEnable,
  output logic              mem_ReadWrite,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wdata_oe,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic              alu_valid,
  input  logic              alu_done,
  input  logic [DATA_W-1:0] alu_result
);

  // Counter only has to reach TIMEOUT-1, so $clog2(TIMEOUT) bits never wrap.
  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    StIdle,
    StRdA,
    StRdB,
    StLatB,
    StExec,
    StWait,
    StWrC,
    StDone,
    StErr
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_a_q, addr_a_d;
  logic [ADDR_W-1:0] addr_b_q, addr_b_d;
  logic [ADDR_W-1:0] addr_dst_q, addr_dst_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_nen_q, mem_nen_d;
  logic              mem_rw_q, mem_rw_d;
  logic              mem_oe_q, mem_oe_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  logic              alu_valid_q, alu_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic accept;
  assign accept = (state_q == StIdle) && start;

  // Next-state, timeout counter and operand/address capture.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_a_d    = addr_a_q;
    addr_b_d    = addr_b_q;
    addr_dst_d  = addr_dst_q;
    mem_wdata_d = mem_wdata_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          addr_a_d   = addr_a;
          addr_b_d   = addr_b;
          addr_dst_d = addr_dst;
          state_d    = StRdA;
        end
      end
      StRdA: state_d = StRdB;
      StRdB: begin
        // Row A, requested in RD_A, is on the bus this cycle.
        alu_a_d = mem_rdata;
        state_d = StLatB;
      end
      StLatB: begin
        alu_b_d = mem_rdata;
        state_d = StExec;
      end
      StExec: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        // A result arriving on the last allowed cycle still wins over the timeout.
        if (alu_done) begin
          mem_wdata_d = alu_result;
          state_d     = StWrC;
        end else if (cnt_q == CntLast) begin
          state_d = StErr;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWrC:   state_d = StDone;
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode for the state being entered; loaded into the output flops.
  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_nen_d   = 1'b1;
    mem_rw_d    = 1'b1;
    mem_oe_d    = 1'b0;
    alu_valid_d = 1'b0;
    busy_d      = (state_d != StIdle);
    done_d      = (state_d == StDone);
    err_d       = (state_d == StErr);

    unique case (state_d)
      StRdA: begin
        mem_addr_d = addr_a_d;
        mem_nen_d  = 1'b0;
      end
      StRdB: begin
        mem_addr_d = addr_b_d;
        mem_nen_d  = 1'b0;
      end
      StExec: alu_valid_d = 1'b1;
      StWrC: begin
        mem_addr_d = addr_dst_d;
        mem_nen_d  = 1'b0;
        mem_rw_d   = 1'b0;
        mem_oe_d   = 1'b1;
      end
      default: ;
    endcase
  end

  // State, capture and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      addr_dst_q  <= '0;
      mem_addr_q  <= '0;
      mem_nen_q   <= 1'b1;
      mem_rw_q    <= 1'b1;
      mem_oe_q    <= 1'b0;
      mem_wdata_q <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_a_q    <= addr_a_d;
      addr_b_q    <= addr_b_d;
      addr_dst_q  <= addr_dst_d;
      mem_addr_q  <= mem_addr_d;
      mem_nen_q   <= mem_nen_d;
      mem_rw_q    <= mem_rw_d;
      mem_oe_q    <= mem_oe_d;
      mem_wdata_q <= mem_wdata_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_valid_q <= alu_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign mem_addr      = mem_addr_q;
  assign mem_nEnable   = mem_nen_q;
  assign mem_ReadWrite = mem_rw_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wdata_oe  = mem_oe_q;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_valid     = alu_valid_q;

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Self-checking bench for matrix_op_sequencer: behavioural RAM, a delayed ALU
// responder (element-wise 16-bit add) and per-scenario test tasks.
module tb_matrix_op_sequencer;

  localparam int DW = 256;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] addr_a = '0, addr_b = '0, addr_dst = '0;
  logic          busy, done, err;
  logic [AW-1:0] mem_addr;
  logic          mem_nEnable, mem_ReadWrite, mem_wdata_oe;
  logic [DW-1:0] mem_wdata, mem_rdata, alu_a, alu_b, alu_result;
  logic          alu_valid;
  logic          alu_done;

  int checks = 0;
  int errors = 0;

  matrix_op_sequencer #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .addr_a       (addr_a),
    .addr_b       (addr_b),
    .addr_dst     (addr_dst),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .mem_addr     (mem_addr),
    .mem_nEnable  (mem_nEnable),
    .mem_ReadWrite(mem_ReadWrite),
    .mem_wdata    (mem_wdata),
    .mem_wdata_oe (mem_wdata_oe),
    .mem_rdata    (mem_rdata),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_valid    (alu_valid),
    .alu_done     (alu_done),
    .alu_result   (alu_result)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] elem_add(input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic [DW-1:0] r;
    for (int i = 0; i < 16; i++) r[i*16 +: 16] = x[i*16 +: 16] + y[i*16 +: 16];
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_row();
    logic [DW-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // RAM model: read data appears the cycle after the read is sampled.
  logic [DW-1:0] ram [8];
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;
  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (!mem_nEnable) begin
      if (mem_ReadWrite) mem_rdata <= ram[mem_addr];
      else if (mem_wdata_oe) ram[mem_addr] <= mem_wdata;
    end
  end

  // ALU model: answers cfg_delay WAIT cycles after the operand pulse; 0 = never.
  int cfg_delay = 1;
  int pending = 0;
  always @(negedge clk) begin
    alu_done <= 1'b0;
    if (!reset) pending <= 0;
    else if (alu_valid) pending <= cfg_delay;
    else if (pending > 1) pending <= pending - 1;
    else if (pending == 1) begin
      pending    <= 0;
      alu_done   <= 1'b1;
      alu_result <= elem_add(alu_a, alu_b);
    end
  end

  // Pin-level event counters.
  int n_rd = 0, n_wr = 0, n_done = 0, n_err = 0, n_badoe = 0;
  always @(posedge clk) begin
    if (!mem_nEnable && mem_ReadWrite) n_rd <= n_rd + 1;
    if (!mem_nEnable && !mem_ReadWrite) n_wr <= n_wr + 1;
    if (done) n_done <= n_done + 1;
    if (err) n_err <= n_err + 1;
    if (mem_wdata_oe && !(!mem_nEnable && !mem_ReadWrite)) n_badoe <= n_badoe + 1;
  end

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
    @(negedge clk);
    pl_addr = a;
    pl_data = v;
    pl_en   = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // One operation; lat = cycles from the operand pulse to done/err.
  task automatic run_op(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] d,
                        output int lat, output bit got_done, output bit got_err);
    int t, v_at;
    @(negedge clk);
    addr_a = a; addr_b = b; addr_dst = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got_done = 0; got_err = 0; t = 0; v_at = 0; lat = -1;
    while (!got_done && !got_err && t < 300) begin
      if (alu_valid) v_at = t;
      if (done) begin got_done = 1; lat = t - v_at; end
      if (err) begin got_err = 1; lat = t - v_at; end
      if (!got_done && !got_err) begin
        @(negedge clk);
        t++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, err, alu_valid, mem_nEnable, mem_ReadWrite, mem_wdata_oe} !== 7'b0000110) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 0000110",
               {busy, done, err, alu_valid, mem_nEnable, mem_ReadWrite, mem_wdata_oe});
    end
    checks++;
    if ((alu_a | alu_b | mem_wdata) !== '0 || mem_addr !== '0) begin
      errors++;
      $display("FAIL reset_data got addr %0d a|b|wd %h exp 0", mem_addr, alu_a | alu_b | mem_wdata);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat, rd0, wr0, dn0;
    bit gd, ge;
    preload(3'd2, 256'h0A);
    preload(3'd5, 256'h14);
    cfg_delay = 3;
    rd0 = n_rd; wr0 = n_wr; dn0 = n_done;
    run_op(3'd2, 3'd5, 3'd7, lat, gd, ge);
    checks++;
    if (!gd || ge || lat != 5) begin
      errors++;
      $display("FAIL basic_done got done %0d err %0d lat %0d exp 1 0 5", gd, ge, lat);
    end
    checks++;
    if (alu_a !== 256'h0A || alu_b !== 256'h14) begin
      errors++;
      $display("FAIL basic_operands got %h %h exp 0a 14", alu_a, alu_b);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy got %b exp 0", busy); end
    @(negedge clk);
    checks++;
    if (ram[7] !== 256'h1E) begin errors++; $display("FAIL basic_row7 got %h exp 1e", ram[7]); end
    checks++;
    if (n_done - dn0 != 1 || n_rd - rd0 != 2 || n_wr - wr0 != 1) begin
      errors++;
      $display("FAIL basic_counts got done %0d rd %0d wr %0d exp 1 2 1",
               n_done - dn0, n_rd - rd0, n_wr - wr0);
    end
  endtask

  task automatic test_same_row();
    int lat, rd0, wr0;
    bit gd, ge;
    preload(3'd3, 256'hFFFF);
    cfg_delay = 2;
    rd0 = n_rd; wr0 = n_wr;
    run_op(3'd3, 3'd3, 3'd3, lat, gd, ge);
    checks++;
    if (!gd || alu_a !== 256'hFFFF || alu_b !== 256'hFFFF) begin
      errors++;
      $display("FAIL same_operands got done %0d %h %h exp 1 ffff ffff", gd, alu_a, alu_b);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (ram[3] !== elem_add(256'hFFFF, 256'hFFFF)) begin
      errors++;
      $display("FAIL same_row3 got %h exp %h", ram[3], elem_add(256'hFFFF, 256'hFFFF));
    end
    checks++;
    if (n_rd - rd0 != 2 || n_wr - wr0 != 1) begin
      errors++;
      $display("FAIL same_ramcycles got rd %0d wr %0d exp 2 1", n_rd - rd0, n_wr - wr0);
    end
  endtask

  task automatic test_timeout();
    int lat, wr0, dn0, er0;
    bit gd, ge;
    preload(3'd4, 256'hDEAD_BEEF);
    cfg_delay = 0;
    wr0 = n_wr; dn0 = n_done; er0 = n_err;
    run_op(3'd1, 3'd2, 3'd4, lat, gd, ge);
    // WAIT entered one cycle after the operand pulse, err 64 cycles later.
    checks++;
    if (!ge || gd || lat != 65) begin
      errors++;
      $display("FAIL timeout_err got err %0d done %0d lat %0d exp 1 0 65", ge, gd, lat);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (n_wr != wr0 || n_done != dn0 || n_err - er0 != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_counts got wr %0d done %0d err %0d busy %b exp 0 0 1 0",
               n_wr - wr0, n_done - dn0, n_err - er0, busy);
    end
    checks++;
    if (ram[4] !== 256'hDEAD_BEEF) begin
      errors++;
      $display("FAIL timeout_row4 got %h exp deadbeef", ram[4]);
    end
  endtask

  task automatic test_start_held();
    int t, rd0, wr0, dn0;
    logic [DW-1:0] r0, r1;
    r0 = rand_row(); r1 = rand_row();
    preload(3'd0, r0);
    preload(3'd1, r1);
    cfg_delay = 1;
    rd0 = n_rd; wr0 = n_wr; dn0 = n_done;
    @(negedge clk);
    addr_a = 3'd0; addr_b = 3'd1; addr_dst = 3'd6; start = 1'b1;
    repeat (20) @(negedge clk);
    start = 1'b0;
    t = 0;
    while (busy && t < 60) begin @(negedge clk); t++; end
    repeat (2) @(negedge clk);
    // Each op spans 8 cycles including its IDLE visit: 20 start cycles -> 3 ops.
    checks++;
    if (n_done - dn0 != 3 || n_rd - rd0 != 6 || n_wr - wr0 != 3) begin
      errors++;
      $display("FAIL held_ops got done %0d rd %0d wr %0d exp 3 6 3",
               n_done - dn0, n_rd - rd0, n_wr - wr0);
    end
    checks++;
    if (ram[6] !== elem_add(r0, r1)) begin
      errors++;
      $display("FAIL held_row6 got %h exp %h", ram[6], elem_add(r0, r1));
    end
  endtask

  task automatic test_reset_mid();
    int t, wr0, dn0, er0;
    preload(3'd6, 256'h5A5A);
    cfg_delay = 30;
    wr0 = n_wr; dn0 = n_done; er0 = n_err;
    @(negedge clk);
    addr_a = 3'd0; addr_b = 3'd1; addr_dst = 3'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (!alu_valid && t < 20) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (t >= 20 || {busy, done, err, mem_nEnable, mem_wdata_oe} !== 5'b00010) begin
      errors++;
      $display("FAIL rst_wait_outs got %b (t %0d) exp 00010",
               {busy, done, err, mem_nEnable, mem_wdata_oe}, t);
    end
    reset = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if (ram[6] !== 256'h5A5A || n_wr != wr0 || n_done != dn0 || n_err != er0) begin
      errors++;
      $display("FAIL rst_wait_quiet got row6 %h wr %0d done %0d err %0d exp 5a5a 0 0 0",
               ram[6], n_wr - wr0, n_done - dn0, n_err - er0);
    end
    cfg_delay = 1;
    dn0 = n_done; er0 = n_err;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (!(!mem_nEnable && !mem_ReadWrite) && t < 30) begin @(negedge clk); t++; end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (t >= 30 || {busy, done, err, mem_nEnable, mem_wdata_oe} !== 5'b00010) begin
      errors++;
      $display("FAIL rst_wrc_outs got %b (t %0d) exp 00010",
               {busy, done, err, mem_nEnable, mem_wdata_oe}, t);
    end
    reset = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (n_done != dn0 || n_err != er0) begin
      errors++;
      $display("FAIL rst_wrc_pulse got done %0d err %0d exp 0 0", n_done - dn0, n_err - er0);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] shadow [8];
    logic [DW-1:0] expv;
    logic [AW-1:0] a, b, d;
    int lat, dly;
    bit gd, ge;
    for (int i = 0; i < 8; i++) begin
      shadow[i] = rand_row();
      preload(AW'(i), shadow[i]);
    end
    for (int n = 0; n < 8; n++) begin
      a = AW'($urandom_range(0, 7));
      b = AW'($urandom_range(0, 7));
      d = AW'($urandom_range(0, 7));
      dly = $urandom_range(1, 6);
      cfg_delay = dly;
      expv = elem_add(shadow[a], shadow[b]);
      run_op(a, b, d, lat, gd, ge);
      checks++;
      if (!gd || ge || lat != dly + 2) begin
        errors++;
        $display("FAIL rand_done[%0d] got done %0d err %0d lat %0d exp 1 0 %0d",
                 n, gd, ge, lat, dly + 2);
      end
      checks++;
      if (alu_a !== shadow[a] || alu_b !== shadow[b]) begin
        errors++;
        $display("FAIL rand_operands[%0d] got %h %h exp %h %h", n, alu_a, alu_b, shadow[a],
                 shadow[b]);
      end
      shadow[d] = expv;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ram[i] !== shadow[i]) begin
        errors++;
        $display("FAIL rand_row[%0d] got %h exp %h", i, ram[i], shadow[i]);
      end
    end
    checks++;
    if (n_badoe != 0) begin
      errors++;
      $display("FAIL oe_outside_write got %0d exp 0", n_badoe);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) ram[i] = '0;
    test_reset();
    test_basic();
    test_same_row();
    test_timeout();
    test_start_held();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
